// File: rtl/seq_mul_pkg.sv
// Shared definitions for the sequential shift-add multiplier: controller state encoding and
// product-width helper.
package seq_mul_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic int unsigned prod_width(input int unsigned w);
    return 2 * w;
  endfunction

endpackage

// File: rtl/seq_mul_ctrl.sv
// Controller for the sequential multiplier: IDLE/RUN/DONE FSM plus iteration counter, issuing
// load/step/finish strobes to the datapath.
module seq_mul_ctrl
  import seq_mul_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  localparam int unsigned CNT_W = $clog2(WIDTH)
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic start_i,
  output logic load_o,
  output logic step_o,
  output logic finish_o,
  output logic busy_o,
  output logic done_o
);

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    load_o   = 1'b0;
    step_o   = 1'b0;
    finish_o = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_i) begin
          load_o  = 1'b1;
          cnt_d   = '0;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        // start is ignored here: a running operation cannot be recaptured
        step_o = 1'b1;
        if (cnt_q == CntLast) begin
          finish_o = 1'b1;
          state_d  = ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy_o = (state_q == ST_RUN);
  assign done_o = (state_q == ST_DONE);

endmodule

// File: rtl/seq_mul_param.sv
// Parametrised WIDTH x WIDTH sequential shift-add multiplier, signed or unsigned per operation,
// one multiplier bit per cycle with a held result register.
module seq_mul_param
  import seq_mul_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  localparam int unsigned CNT_W = $clog2(WIDTH)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         signed_mode,
  input  logic [WIDTH-1:0]             a,
  input  logic [WIDTH-1:0]             b,
  output logic                         busy,
  output logic                         done,
  output logic [prod_width(WIDTH)-1:0] op
);

  localparam int unsigned PW = prod_width(WIDTH);

  logic load, step, finish;

  seq_mul_ctrl #(
    .WIDTH (WIDTH)
  ) u_ctrl (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .start_i  (start),
    .load_o   (load),
    .step_o   (step),
    .finish_o (finish),
    .busy_o   (busy),
    .done_o   (done)
  );

  // hi_q carries one guard bit so the running sum never overflows in either mode
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH:0]   hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             sgn_q, sgn_d;
  logic [PW-1:0]    op_q, op_d;

  logic [WIDTH:0]   a_ext, addend, sum, hi_shift;
  logic [WIDTH-1:0] lo_shift;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      sgn_q <= 1'b0;
      op_q  <= '0;
    end else begin
      a_q   <= a_d;
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      sgn_q <= sgn_d;
      op_q  <= op_d;
    end
  end

  always_comb begin
    a_ext  = sgn_q ? {a_q[WIDTH-1], a_q} : {1'b0, a_q};
    addend = '0;
    if (lo_q[0]) begin
      // In signed mode the multiplier MSB carries negative weight, so subtract on the last step
      addend = (finish && sgn_q) ? (~a_ext + 1'b1) : a_ext;
    end
    sum      = hi_q + addend;
    hi_shift = {sgn_q & sum[WIDTH], sum[WIDTH:1]};
    lo_shift = {sum[0], lo_q[WIDTH-1:1]};
  end

  always_comb begin
    a_d   = a_q;
    hi_d  = hi_q;
    lo_d  = lo_q;
    sgn_d = sgn_q;
    op_d  = op_q;
    if (load) begin
      a_d   = a;
      lo_d  = b;
      hi_d  = '0;
      sgn_d = signed_mode;
    end else if (step) begin
      hi_d = hi_shift;
      lo_d = lo_shift;
      if (finish) begin
        op_d = {hi_shift[WIDTH-1:0], lo_shift};
      end
    end
  end

  assign op = op_q;

endmodule

// File: doc/seq_mul_param.md
Name: seq_mul_param

Overview:
Parametrised successor to the fixed 4x4 sequential shift-add multiplier. Multiplies two WIDTH-bit operands over WIDTH clock cycles, using one add and one shift per cycle. Adds a per-operation signed/unsigned mode, a busy/done handshake, a held result and an asynchronous active-low reset. Sits beside the ALU datapath as a multi-cycle functional unit that a controller launches with a one-cycle start pulse.

Parameters:
WIDTH, 4, operand width in bits; legal range 2..32; the product is 2*WIDTH bits.
CNT_W, $clog2(WIDTH), width of the iteration counter; derived, never overridden.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  launch request; sampled on the rising edge.
signed_mode  input  1  1 = two's-complement operands, 0 = unsigned; captured with start.
a  input  WIDTH  multiplicand; captured with start.
b  input  WIDTH  multiplier; captured with start.
busy  output  1  high while an operation is in progress.
done  output  1  one-cycle pulse when op is updated.
op  output  2*WIDTH  product of the last completed operation, held until the next completion.

Behaviour:
- Reset: rst_n low forces the state to IDLE and clears counter=0, busy=0, done=0, op=0 and all internal registers, immediately and independent of clk.
- States are IDLE, RUN and DONE.
- IDLE or DONE, start=1 at edge E0: capture a, b and signed_mode; clear the accumulator; counter=0; go to RUN; busy=1 from E0.
- RUN: each edge E1..E_WIDTH processes one multiplier bit, LSB first, with a conditional add of the multiplicand followed by a right shift.
- At E_WIDTH (counter==WIDTH-1): load op with the final product, set done=1 and busy=0, and go to DONE.
- DONE lasts exactly one cycle. The next edge clears done and goes to IDLE, or goes to RUN if start=1. Back-to-back operations are therefore legal with no idle gap.
- Latency: op is valid and done=1 during the cycle after edge E_WIDTH. For WIDTH=4 that is 4 edges after start is sampled.
- Throughput: one result per WIDTH+1 cycles.
- start while busy=1 is ignored: no recapture and no effect on the counter or result.
- Operand inputs are don't-care except at the sampling edge.
- Unsigned mode: op = a*b exact; the maximum (2^W-1)^2 fits in 2W bits.
- Signed mode: op = two's-complement product of sign-extended a and b in 2W bits.
  - The most-negative case (-2^(W-1))^2 = 2^(2W-2) is exact and positive.
  - Any one zero operand gives op=0 with no negative zero.
- Implementation freedom: Booth radix-2 or sign-magnitude with a final conditional negate are both acceptable, provided latency is unchanged.
- op changes only at the E_WIDTH edge or on reset. It never exposes partial products.
- Reset mid-RUN aborts the operation: no done pulse, and op=0.
- Start coincident with reset deassertion: the first edge with rst_n high may sample start normally.

Decomposition:
- Shared package seq_mul_pkg holds:
  - state encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2;
  - a localparam helper for the product width.
- One sub-module, seq_mul_ctrl, holds the FSM and iteration counter. It produces load, step and finish strobes plus busy and done.
- The top level holds the operand, accumulator and result registers and the add/shift datapath.

Test Plan:
- WIDTH=4, unsigned, a=5, b=9, start pulsed for 1 cycle -> busy for 4 cycles, then done=1 for 1 cycle, op=8'h2D, op held afterwards.
- WIDTH=4, unsigned, a=13, b=5 -> op=8'h41. Same operands signed (-3*5) -> op=8'hF1. Signed a=4'b1000, b=4'b1000 -> op=8'h40. Unsigned 15*15 -> op=8'hE1.
- WIDTH=8, signed, a=8'h80, b=8'h7F -> op=16'hC080, done 8 edges after the start edge. Unsigned 8'hFF*8'hFF -> op=16'hFE01.
- start re-pulsed with a=2, b=3 while busy during a 5*9 operation -> op=8'h2D, only one done pulse.
- start held high in the DONE cycle with a=6, b=7 -> op first 8'h2D, then 8'h2A exactly 5 cycles later, with no idle cycle between operations.
- rst_n pulled low asynchronously at mid-clock during RUN of 13*5 -> busy, done and op go to 0 immediately, no done pulse follows, and the next operation (3*3) yields op=8'h09.
